if_fetch_unit: RTL and testbench

- Instruction-fetch initiator for the instruction ROM.
- Owns the program counter and drives the ROM chip-enable and byte address.
- Captures the ROM's same-cycle instruction into the IF/ID pipeline register for the decode stage.
- Handles stall, branch redirect, exception flush and misaligned-fetch detection.

---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_fetch_unit_if.sv | 38 +++
 rtl/if_fetch_unit_if_id_reg.sv | 76 +++++++
 rtl/if_fetch_unit.sv | 80 ++++++++
 tb/tb_if_fetch_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg : shared constants and helpers for the fetch stage. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package if_fetch_unit_pkg;

   localparam logic RST_ENABLE    = 1'b1;
   localparam logic CHIP_ENABLE   = 1'b1;
   localparam logic CHIP_DISABLE  = 1'b0;
   localparam logic STOP          = 1'b1;

   localparam int   INST_ADDR_BUS = 32;
   localparam int   INST_BUS      = 32;
   localparam int   STALL_W       = 6;

   localparam int   STALL_PC      = 0;
   localparam int   STALL_IF      = 1;
   localparam int   STALL_ID      = 2;

   // Instructions are word aligned; any low address bit set is a fetch fault.
   function automatic logic pc_is_aligned(input logic [1:0] pc_low);
      return (pc_low == 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if : pipeline-control, ROM and IF/ID signals of the fetch stage. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface if_fetch_unit_if
   import if_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS,
   parameter int INST_W = INST_BUS
);

   logic [STALL_W-1:0] stall;
   logic               flush;
   logic [ADDR_W-1:0]  new_pc;
   logic               branch_flag;
   logic [ADDR_W-1:0]  branch_target;
   logic               rom_ce;
   logic [ADDR_W-1:0]  rom_addr;
   logic [INST_W-1:0]  rom_inst;
   logic [ADDR_W-1:0]  id_pc;
   logic [INST_W-1:0]  id_inst;
   logic               id_valid;
   logic               id_excpt_adel;

   modport master (
      input  stall, flush, new_pc, branch_flag, branch_target, rom_inst,
      output rom_ce, rom_addr, id_pc, id_inst, id_valid, id_excpt_adel
   );

   modport slave (
      output stall, flush, new_pc, branch_flag, branch_target, rom_inst,
      input  rom_ce, rom_addr, id_pc, id_inst, id_valid, id_excpt_adel
   );

endinterface

`default_nettype wire

// File: rtl/if_fetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if_id_reg : IF/ID pipeline register with flush/bubble/hold. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit_if_id_reg
   import if_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS,
   parameter int INST_W = INST_BUS
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              flush,
   input  wire logic              stall_if,
   input  wire logic              stall_id,
   input  wire logic              capture_en,
   input  wire logic [ADDR_W-1:0] pc_in,
   input  wire logic [INST_W-1:0] inst_in,
   input  wire logic              adel_in,
   output logic      [ADDR_W-1:0] id_pc,
   output logic      [INST_W-1:0] id_inst,
   output logic                   id_valid,
   output logic                   id_excpt_adel
);

   logic [ADDR_W-1:0] pc_d,    pc_q;
   logic [INST_W-1:0] inst_d,  inst_q;
   logic              valid_d, valid_q;
   logic              adel_d,  adel_q;

   always_comb begin
      pc_d    = '0;
      inst_d  = '0;
      valid_d = 1'b0;
      adel_d  = 1'b0;
      if (flush) begin
         pc_d = '0;
      end else if (stall_if && !stall_id) begin
         // IF stalled but ID moving on: decode must see a bubble
         pc_d = '0;
      end else if (stall_if && stall_id) begin
         pc_d    = pc_q;
         inst_d  = inst_q;
         valid_d = valid_q;
         adel_d  = adel_q;
      end else if (capture_en) begin
         pc_d    = pc_in;
         inst_d  = inst_in;
         valid_d = 1'b1;
         adel_d  = adel_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         pc_q    <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
         adel_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         adel_q  <= adel_d;
      end
   end

   assign id_pc         = pc_q;
   assign id_inst       = inst_q;
   assign id_valid      = valid_q;
   assign id_excpt_adel = adel_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit : program counter, ROM fetch and IF/ID capture. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = INST_ADDR_BUS,
   parameter int                INST_W   = INST_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire logic      clk,
   input  wire logic      rst,
   if_fetch_unit_if.master bus
);

   logic              ce_d, ce_q;
   logic [ADDR_W-1:0] pc_d, pc_q;
   logic              pc_aligned;
   logic [INST_W-1:0] fetch_inst;
   logic              unused_stall_bits;

   assign unused_stall_bits = ^bus.stall[STALL_W-1:STALL_ID+1];

   assign pc_aligned = pc_is_aligned(pc_q[1:0]);
   assign fetch_inst = pc_aligned ? bus.rom_inst : '0;

   always_comb begin
      ce_d = CHIP_ENABLE;
      pc_d = pc_q;
      // The enabling edge leaves pc alone so RESET_PC is the first fetch.
      if (ce_q == CHIP_ENABLE) begin
         if (bus.flush) begin
            pc_d = bus.new_pc;
         end else if (bus.stall[STALL_PC] == STOP) begin
            pc_d = pc_q;
         end else if (bus.branch_flag) begin
            pc_d = bus.branch_target;
         end else begin
            pc_d = pc_q + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         ce_q <= CHIP_DISABLE;
         pc_q <= RESET_PC;
      end else begin
         ce_q <= ce_d;
         pc_q <= pc_d;
      end
   end

   assign bus.rom_addr = pc_q;
   assign bus.rom_ce   = ce_q & pc_aligned;

   if_fetch_unit_if_id_reg #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_if_id_reg (
      .clk           (clk),
      .rst           (rst),
      .flush         (bus.flush),
      .stall_if      (bus.stall[STALL_IF]),
      .stall_id      (bus.stall[STALL_ID]),
      .capture_en    (ce_q),
      .pc_in         (pc_q),
      .inst_in       (fetch_inst),
      .adel_in       (~pc_aligned),
      .id_pc         (bus.id_pc),
      .id_inst       (bus.id_inst),
      .id_valid      (bus.id_valid),
      .id_excpt_adel (bus.id_excpt_adel)
   );

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit : directed plan plus randomized run against a reference model. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   if_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

   if_fetch_unit #(
      .ADDR_W   (32),
      .INST_W   (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // ROM content is a hash of the address; misaligned reads return junk on purpose.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always_comb bus.rom_inst = rom_word(bus.rom_addr);

   // Reference model state.
   logic        m_ce;
   logic [31:0] m_pc;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_inst;
   logic        m_id_valid;
   logic        m_id_adel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ce       = 1'b0;
      m_pc       = RST_PC;
      m_id_pc    = 32'h0;
      m_id_inst  = 32'h0;
      m_id_valid = 1'b0;
      m_id_adel  = 1'b0;
   endtask

   // One rising edge, using the inputs currently on the bus.
   task automatic model_edge();
      logic misaligned;
      misaligned = (m_pc % 4) != 0;
      if (bus.flush || (bus.stall[1] && !bus.stall[2]) || (!bus.stall[1] && !m_ce)) begin
         m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
      end else if (!bus.stall[1]) begin
         m_id_pc    = m_pc;
         m_id_inst  = misaligned ? 32'h0 : rom_word(m_pc);
         m_id_valid = 1'b1;
         m_id_adel  = misaligned;
      end
      if (m_ce) begin
         if (bus.flush)            m_pc = bus.new_pc;
         else if (bus.stall[0])    m_pc = m_pc;
         else if (bus.branch_flag) m_pc = bus.branch_target;
         else                      m_pc = m_pc + 32'd4;
      end
      m_ce = 1'b1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rom_ce"},   32'(bus.rom_ce),        32'(m_ce && (m_pc % 4) == 0));
      chk({tag, ".rom_addr"}, bus.rom_addr,            m_pc);
      chk({tag, ".id_pc"},    bus.id_pc,               m_id_pc);
      chk({tag, ".id_inst"},  bus.id_inst,             m_id_inst);
      chk({tag, ".id_valid"}, 32'(bus.id_valid),      32'(m_id_valid));
      chk({tag, ".id_adel"},  32'(bus.id_excpt_adel), 32'(m_id_adel));
   endtask

   task automatic cycle(input string tag, input logic [5:0] st, input logic fl,
                        input logic [31:0] np, input logic bf, input logic [31:0] bt);
      bus.stall         = st;
      bus.flush         = fl;
      bus.new_pc        = np;
      bus.branch_flag   = bf;
      bus.branch_target = bt;
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 9) == 0) t = t + 32'($urandom_range(1, 3));
      return t;
   endfunction

   initial begin
      rst = 1'b1;
      bus.stall = 6'b0; bus.flush = 1'b0; bus.new_pc = 32'h0;
      bus.branch_flag = 1'b0; bus.branch_target = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      chk("reset.ce_low", 32'(bus.rom_ce), 32'h0);
      rst = 1'b0;

      cycle("rel", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("rel.ce_on", 32'(bus.rom_ce), 32'h1);
      chk("rel.addr0", bus.rom_addr, 32'h0);
      cycle("seq4", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("seq4.addr", bus.rom_addr, 32'h4);
      chk("seq4.word0", bus.id_inst, rom_word(32'h0));
      cycle("seq8", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("seq8.addr", bus.rom_addr, 32'h8);
      cycle("br40", 6'b0, 1'b0, 32'h0, 1'b1, 32'h40);
      chk("br40.addr", bus.rom_addr, 32'h40);
      cycle("br44", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("br44.addr", bus.rom_addr, 32'h44);
      cycle("br10", 6'b0, 1'b0, 32'h0, 1'b1, 32'h10);

      repeat (2) cycle("hold", 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("hold.id_pc", bus.id_pc, 32'h44);
      chk("hold.addr", bus.rom_addr, 32'h10);
      repeat (2) cycle("bubble", 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("bubble.valid", 32'(bus.id_valid), 32'h0);
      chk("bubble.addr", bus.rom_addr, 32'h10);
      cycle("unstall", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      cycle("flush", 6'b0, 1'b1, 32'h20, 1'b1, 32'h80);
      chk("flush.addr", bus.rom_addr, 32'h20);
      chk("flush.id_pc", bus.id_pc, 32'h0);

      cycle("mis", 6'b0, 1'b0, 32'h0, 1'b1, 32'h42);
      chk("mis.ce_off", 32'(bus.rom_ce), 32'h0);
      cycle("mis_id", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("mis_id.adel", 32'(bus.id_excpt_adel), 32'h1);
      chk("mis_id.pc", bus.id_pc, 32'h42);
      chk("mis_id.inst", bus.id_inst, 32'h0);
      cycle("mis_next", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("mis_next.addr", bus.rom_addr, 32'h4A);

      cycle("wrap_br", 6'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      cycle("wrap", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("wrap.addr", bus.rom_addr, 32'h0);

      cycle("to1c", 6'b0, 1'b0, 32'h0, 1'b1, 32'h1C);
      cycle("st1c", 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("st1c.addr", bus.rom_addr, 32'h1C);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_all("arst");
      chk("arst.addr", bus.rom_addr, RST_PC);
      @(negedge clk);
      check_all("arst_hold");
      rst = 1'b0;
      bus.stall = 6'b0;

      for (int i = 0; i < 400; i++) begin
         logic [5:0] st;
         st = 6'($urandom_range(0, 63));
         for (int b = 0; b < 3; b++) st[b] = ($urandom_range(0, 99) < 15);
         cycle("rand", st, ($urandom_range(0, 99) < 5), rand_target(),
               ($urandom_range(0, 99) < 20), rand_target());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
